// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream buffer: the beat layout and the
// packet-mode encodings understood by axis_fifo_buf.
`ifndef AXIS_PKG_SV
`define AXIS_PKG_SV

// Beat layout {TDATA, TKEEP, TUSER, TLAST}; the macro lets each user pick its own widths.
`define AXIS_BEAT_T(DW, KW, UW) struct packed { logic [(DW)-1:0] data; logic [(KW)-1:0] keep; logic [(UW)-1:0] user; logic last; }

package axis_pkg;
  localparam int AXIS_STREAM = 32'd0;
  localparam int AXIS_PKT    = 32'd1;
endpackage

`endif

// File: rtl/axis_fifo_mem.sv
// Beat storage for axis_fifo_buf: DEPTH registers, one write port and one
// combinational read port. Contents are deliberately not reset.
module axis_fifo_mem #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next contents: only the addressed entry can change.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d[waddr] = mem_q[waddr];
    end
  end

  // Storage registers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_fifo_buf.sv
// DEPTH-entry AXI4-Stream buffer with fill-level status and optional
// store-and-forward release on TLAST. Both ready/valid outputs come from flops.
module axis_fifo_buf
  import axis_pkg::*;
#(
  parameter  int DATA_W   = 64,
  parameter  int USER_W   = 1,
  parameter  int DEPTH    = 4,
  parameter  int PKT_MODE = AXIS_STREAM,
  localparam int KEEP_W   = DATA_W / 8,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              S_TVALID,
  output logic              S_TREADY,
  input  logic [DATA_W-1:0] S_TDATA,
  input  logic [KEEP_W-1:0] S_TKEEP,
  input  logic [USER_W-1:0] S_TUSER,
  input  logic              S_TLAST,
  output logic              M_TVALID,
  input  logic              M_TREADY,
  output logic [DATA_W-1:0] M_TDATA,
  output logic [KEEP_W-1:0] M_TKEEP,
  output logic [USER_W-1:0] M_TUSER,
  output logic              M_TLAST,
  output logic [CNT_W-1:0]  level,
  output logic [CNT_W-1:0]  pkt_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LVL_ZERO = '0;
  localparam logic [CNT_W-1:0] LVL_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  typedef `AXIS_BEAT_T(DATA_W, KEEP_W, USER_W) beat_t;
  localparam int BEAT_W = $bits(beat_t);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d, pkt_level_q, pkt_level_d;
  logic             en_q, en_d;
  logic             s_tready_s, m_tvalid_s, wr_en_s, rd_en_s;
  beat_t            wr_beat_s, rd_beat_s;

  assign wr_beat_s = {S_TDATA, S_TKEEP, S_TUSER, S_TLAST};

  axis_fifo_mem #(
    .WIDTH(BEAT_W),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (ACLK),
    .we   (wr_en_s),
    .waddr(wr_ptr_q),
    .wdata(wr_beat_s),
    .raddr(rd_ptr_q),
    .rdata(rd_beat_s)
  );

  // Handshakes; a full buffer releases data even without TLAST so long packets cannot deadlock.
  always_comb begin
    s_tready_s = en_q && (level_q != LVL_FULL);
    if (PKT_MODE == AXIS_PKT) begin
      m_tvalid_s = (level_q != LVL_ZERO) && ((pkt_level_q != LVL_ZERO) || (level_q == LVL_FULL));
    end else begin
      m_tvalid_s = (level_q != LVL_ZERO);
    end
    wr_en_s = S_TVALID && s_tready_s;
    rd_en_s = m_tvalid_s && M_TREADY;
  end

  // Pointer and counter updates.
  always_comb begin
    en_d     = 1'b1;
    wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_en_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({wr_en_s, rd_en_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    case ({wr_en_s && S_TLAST, rd_en_s && rd_beat_s.last})
      2'b10:   pkt_level_d = pkt_level_q + LVL_ONE;
      2'b01:   pkt_level_d = pkt_level_q - LVL_ONE;
      default: pkt_level_d = pkt_level_q;
    endcase
  end

  // State registers; reset drops every stored beat at once.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      en_q        <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_level_q <= '0;
    end else begin
      en_q        <= en_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_level_q <= pkt_level_d;
    end
  end

  assign S_TREADY  = s_tready_s;
  assign M_TVALID  = m_tvalid_s;
  assign M_TDATA   = rd_beat_s.data;
  assign M_TKEEP   = rd_beat_s.keep;
  assign M_TUSER   = rd_beat_s.user;
  assign M_TLAST   = rd_beat_s.last;
  assign level     = level_q;
  assign pkt_level = pkt_level_q;

endmodule
